// File: rtl/inverse_arith_serial.sv
// Bit-serial inverse of the 3-bit arithmetic circuit: recovers A (or B for op 11)
// from the forward result g, one bit per clock through a single full adder.
module inverse_arith_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       s0,
    input  logic       s1,
    input  logic [2:0] g,
    input  logic [2:0] b,
    output logic [2:0] r,
    output logic       ovf,
    output logic       out_valid,
    input  logic       out_ready
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state_reg, state_next;
    logic [1:0] idx_reg;
    logic [1:0] op_reg;
    logic       carry_reg;
    logic [2:0] g_reg, b_reg;
    logic [1:0] res_reg, res_next;
    logic [2:0] r_reg;
    logic       ovf_reg;

    logic [1:0] op_in;
    logic       cin_in;
    logic [2:0] x_vec, y_vec;
    logic       x_bit, y_bit, sum_bit, carry_out;

    assign op_in  = {s1, s0};
    // Only the a-b inverse (g+b) starts with carry 0; the rest add 1 for +1 / two's negation.
    assign cin_in = (op_in != 2'b10);

    always_comb begin
        x_vec = g_reg;
        y_vec = 3'b000;
        case (op_reg)
            2'b00: begin x_vec = g_reg;  y_vec = 3'b000; end
            2'b01: begin x_vec = g_reg;  y_vec = ~b_reg; end
            2'b10: begin x_vec = g_reg;  y_vec = b_reg;  end
            2'b11: begin x_vec = 3'b000; y_vec = ~g_reg; end
            default: ;
        endcase
    end

    always_comb begin
        x_bit = x_vec[0];
        y_bit = y_vec[0];
        case (idx_reg)
            2'd1: begin x_bit = x_vec[1]; y_bit = y_vec[1]; end
            2'd2: begin x_bit = x_vec[2]; y_bit = y_vec[2]; end
            default: ;
        endcase
    end

    assign sum_bit   = x_bit ^ y_bit ^ carry_reg;
    assign carry_out = (x_bit & y_bit) | (x_bit & carry_reg) | (y_bit & carry_reg);

    // Low result bits accumulate privately so r only changes when the result completes.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_res
            assign res_next[gi] = (state_reg == CALC && idx_reg == 2'(gi)) ? sum_bit : res_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
            op_reg    <= 2'b00;
            carry_reg <= 1'b0;
            g_reg     <= 3'b000;
            b_reg     <= 3'b000;
            res_reg   <= 2'b00;
            r_reg     <= 3'b000;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            res_reg   <= res_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        op_reg    <= op_in;
                        g_reg     <= g;
                        b_reg     <= b;
                        carry_reg <= cin_in;
                        idx_reg   <= 2'd0;
                    end
                end
                CALC: begin
                    carry_reg <= carry_out;
                    if (idx_reg == 2'd2) begin
                        idx_reg <= 2'd0;
                        r_reg   <= {sum_bit, res_reg};
                        ovf_reg <= carry_reg ^ carry_out;
                    end else begin
                        idx_reg <= idx_reg + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (idx_reg == 2'd2) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign r         = r_reg;
    assign ovf       = ovf_reg;
endmodule
